// File: rtl/sensor_inject_pkg.sv
// Shared definitions for the sensor_inject frame scheduler.
//   - sched_state_e : scheduler FSM states (idle, streaming a frame, inter-frame gap)
//   - LEN_W, GAP_W  : default widths of the frame-length/count and gap fields
//   - CONTINUOUS    : frame-count value meaning "send frames until stopped"
package sensor_inject_pkg;

    localparam int unsigned LEN_W      = 32;
    localparam int unsigned GAP_W      = 16;
    localparam int unsigned CONTINUOUS = 0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StGap    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sensor_inject_gap_timer.sv
// Loadable down-counter timing the idle gap between frames.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   load        : load load_val into the counter (takes priority over counting)
//   load_val    : value to load; the counter then needs load_val+1 cycles to reach done
//   done        : counter is at zero
module sensor_inject_gap_timer
    import sensor_inject_pkg::*;
#(
    parameter int unsigned W = GAP_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sensor_inject_sched.sv
// Frame scheduler in front of sensor_inject_ctl. Runs the ctl FIFO, passes its recirculating
// stream through unchanged while in a frame, marks the last beat of each frame with TLAST,
// inserts a programmable idle gap between frames and stops after N frames or on request.
// Optional build macro SENSOR_INJECT_SCHED_FRAME_TAG_EN adds m_axis_tuser (frame index) and
// m_axis_tuser_sof (first beat of frame).
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   i_START_wstrobe             : start pulse (rejected with o_ERROR if LEN or FIFO_COUNT is 0)
//   i_STOP_wstrobe              : graceful stop pulse (end of frame, or at once during a gap)
//   i_FRAME_LEN/COUNT/GAP_CYCLES: config, latched on an accepted start; COUNT 0 = continuous
//   i_FIFO_COUNT                : ctl FIFO occupancy
//   o_RUN, o_BUSY, o_ERROR      : FIFO run enable, not-idle, sticky start-rejected
//   o_FRAMES_SENT               : frames completed since the last accepted start
//   s_axis_*                    : stream from ctl;  m_axis_* : framed output stream
module sensor_inject_sched
    import sensor_inject_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned LEN_W = 32,
    parameter int unsigned GAP_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_START_wstrobe,
    input  logic             i_STOP_wstrobe,
    input  logic [LEN_W-1:0] i_FRAME_LEN,
    input  logic [LEN_W-1:0] i_FRAME_COUNT,
    input  logic [GAP_W-1:0] i_GAP_CYCLES,
    input  logic [31:0]      i_FIFO_COUNT,
    output logic             o_RUN,
    output logic             o_BUSY,
    output logic             o_ERROR,
    output logic [31:0]      o_FRAMES_SENT,
    input  logic [DW-1:0]    s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [DW-1:0]    m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
`ifdef SENSOR_INJECT_SCHED_FRAME_TAG_EN
    ,
    output logic [15:0]      m_axis_tuser,
    output logic             m_axis_tuser_sof
`endif
);

    sched_state_e     state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      frames_q, frames_d;
    logic             error_q, error_d;
    logic             stop_pend_q, stop_pend_d;
    logic             run_q;

    logic             in_stream;
    logic             handshake;
    logic             frame_done;
    logic             last_frame;
    logic [31:0]      frames_inc;
    logic             gap_load;
    logic             gap_done;

    // Pass-through datapath. Outside STREAM both directions are blocked so the FIFO holds
    // its position even though o_RUN stays high during a gap.
    assign in_stream     = (state_q == StStream);
    assign m_axis_tdata  = in_stream ? s_axis_tdata : '0;
    assign m_axis_tvalid = in_stream & s_axis_tvalid;
    assign s_axis_tready = in_stream & m_axis_tready;
    assign m_axis_tlast  = in_stream & (beat_q == len_q - LEN_W'(1));
    assign handshake     = m_axis_tvalid & m_axis_tready;
    assign frame_done    = handshake & m_axis_tlast;

    assign frames_inc = frames_q + 32'd1;
    assign last_frame = (count_q != LEN_W'(CONTINUOUS)) && (LEN_W'(frames_inc) == count_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        gap_d       = gap_q;
        beat_d      = beat_q;
        frames_d    = frames_q;
        error_d     = error_q;
        stop_pend_d = stop_pend_q;
        gap_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_START_wstrobe) begin
                    if (i_FRAME_LEN == '0 || i_FIFO_COUNT == '0) begin
                        error_d = 1'b1;
                    end else begin
                        len_d       = i_FRAME_LEN;
                        count_d     = i_FRAME_COUNT;
                        gap_d       = i_GAP_CYCLES;
                        error_d     = 1'b0;
                        frames_d    = '0;
                        beat_d      = '0;
                        stop_pend_d = 1'b0;
                        state_d     = StStream;
                    end
                end
            end
            StStream: begin
                if (i_STOP_wstrobe) begin
                    stop_pend_d = 1'b1;
                end
                if (frame_done) begin
                    frames_d = frames_inc;
                    beat_d   = '0;
                    // A stop arriving on the TLAST beat itself still ends after this frame.
                    if (stop_pend_q || i_STOP_wstrobe || last_frame) begin
                        state_d = StIdle;
                    end else if (gap_q != '0) begin
                        state_d  = StGap;
                        gap_load = 1'b1;
                    end
                end else if (handshake) begin
                    beat_d = beat_q + LEN_W'(1);
                end
            end
            StGap: begin
                if (i_STOP_wstrobe) begin
                    stop_pend_d = 1'b1;
                    state_d     = StIdle;
                end else if (gap_done) begin
                    state_d = StStream;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            beat_q      <= '0;
            frames_q    <= '0;
            error_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            beat_q      <= beat_d;
            frames_q    <= frames_d;
            error_q     <= error_d;
            stop_pend_q <= stop_pend_d;
            run_q       <= (state_d != StIdle);
        end
    end

    // Loaded with GAP-1 on the TLAST beat, so the FSM spends exactly GAP cycles in StGap.
    sensor_inject_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (gap_load),
        .load_val (gap_q - GAP_W'(1)),
        .done     (gap_done)
    );

    assign o_RUN         = run_q;
    assign o_BUSY        = (state_q != StIdle);
    assign o_ERROR       = error_q;
    assign o_FRAMES_SENT = frames_q;

`ifdef SENSOR_INJECT_SCHED_FRAME_TAG_EN
    // frames_q only advances on the TLAST handshake, so during a frame it is the frame index.
    assign m_axis_tuser     = m_axis_tvalid ? frames_q[15:0] : 16'h0;
    assign m_axis_tuser_sof = m_axis_tvalid & (beat_q == '0);
`endif

endmodule

// File: tb/tb_sensor_inject_sched.sv
module tb_sensor_inject_sched;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, stop;
    logic [31:0] frame_len, frame_count, fifo_count;
    logic [15:0] gap_cycles;
    logic        run, busy, err;
    logic [31:0] frames;
    logic [7:0]  s_tdata, m_tdata;
    logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
`ifdef SENSOR_INJECT_SCHED_FRAME_TAG_EN
    logic [15:0] m_tuser;
    logic        m_tuser_sof;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sensor_inject_sched #(
        .DW    (8),
        .LEN_W (32),
        .GAP_W (16)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_START_wstrobe (start),
        .i_STOP_wstrobe  (stop),
        .i_FRAME_LEN     (frame_len),
        .i_FRAME_COUNT   (frame_count),
        .i_GAP_CYCLES    (gap_cycles),
        .i_FIFO_COUNT    (fifo_count),
        .o_RUN           (run),
        .o_BUSY          (busy),
        .o_ERROR         (err),
        .o_FRAMES_SENT   (frames),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tlast    (m_tlast)
`ifdef SENSOR_INJECT_SCHED_FRAME_TAG_EN
        ,
        .m_axis_tuser     (m_tuser),
        .m_axis_tuser_sof (m_tuser_sof)
`endif
    );

    // One record per clock cycle: inputs driven at negedge, outputs expected before the edge.
    typedef struct {
        logic        start;
        logic        stop;
        logic        e_run;
        logic        e_busy;
        logic        e_err;
        logic [31:0] e_frames;
        logic        e_mv;
        logic        e_ml;
        logic        e_sr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic r, input logic b,
                       input logic e, input logic [31:0] f, input logic mv, input logic ml,
                       input logic sr);
        vec_t v;
        v.start = st; v.stop = sp; v.e_run = r; v.e_busy = b; v.e_err = e;
        v.e_frames = f; v.e_mv = mv; v.e_ml = ml; v.e_sr = sr;
        vecs.push_back(v);
    endtask

    task automatic set_cfg(input logic [31:0] l, input logic [31:0] c, input logic [15:0] g,
                           input logic [31:0] f);
        frame_len = l; frame_count = c; gap_cycles = g; fifo_count = f;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start   = vecs[i].start;
            stop    = vecs[i].stop;
            s_tdata = 8'(8'h40 + i);
            #1;
            chk1($sformatf("%s[%0d].run", tag, i), run, vecs[i].e_run);
            chk1($sformatf("%s[%0d].busy", tag, i), busy, vecs[i].e_busy);
            chk1($sformatf("%s[%0d].error", tag, i), err, vecs[i].e_err);
            chk32($sformatf("%s[%0d].frames", tag, i), frames, vecs[i].e_frames);
            chk1($sformatf("%s[%0d].m_tvalid", tag, i), m_tvalid, vecs[i].e_mv);
            chk1($sformatf("%s[%0d].m_tlast", tag, i), m_tlast, vecs[i].e_ml);
            chk1($sformatf("%s[%0d].s_tready", tag, i), s_tready, vecs[i].e_sr);
            if (vecs[i].e_mv) begin
                chk32($sformatf("%s[%0d].m_tdata", tag, i), 32'(m_tdata), 32'(s_tdata));
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        vecs.delete();
    endtask

    initial begin
        int beats, bubbles, hs, exp_d, src, bad_data, bad_last, bad_rdy;
        logic [31:0] lastmask;
        logic done;

        resetn = 1'b0; start = 1'b0; stop = 1'b0;
        s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 8'h00;
        set_cfg(0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk1("reset.run", run, 1'b0);
        chk1("reset.busy", busy, 1'b0);
        chk1("reset.error", err, 1'b0);
        chk32("reset.frames", frames, 32'd0);
        chk1("reset.m_tvalid", m_tvalid, 1'b0);
        chk1("reset.m_tlast", m_tlast, 1'b0);
        resetn = 1'b1;

        // LEN=4, COUNT=3, GAP=2: 12 beats, TLAST on 4/8/12, two idle cycles between frames
        set_cfg(4, 3, 2, 8);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 4; b++) add(0, 0, 1, 1, 0, f, 1, (b == 3), 1);
            if (f < 2) begin
                add(0, 0, 1, 1, 0, f + 1, 0, 0, 0);
                add(0, 0, 1, 1, 0, f + 1, 0, 0, 0);
            end
        end
        add(0, 0, 0, 0, 0, 3, 0, 0, 0);
        run_table("count3");

        // Rejected starts set the sticky error; a valid start clears it and frames
        set_cfg(0, 1, 0, 8);
        add(1, 0, 0, 0, 0, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        run_table("len0");
        set_cfg(4, 1, 0, 0);
        add(1, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        run_table("fifo0");
        set_cfg(2, 1, 0, 8);
        add(1, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        run_table("recover");

        // Continuous LEN=5, GAP=0, stop on beat 7 -> ends at beat 10, no bubbles
        set_cfg(5, 0, 0, 8);
        beats = 0; bubbles = 0; lastmask = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 25; c++) begin
            stop = (beats == 6);
            #1;
            if (m_tvalid && m_tready) begin
                beats++;
                if (m_tlast && beats < 32) lastmask[beats] = 1'b1;
            end else if (beats > 0 && beats < 10) begin
                bubbles++;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        chk32("cont.beats", beats, 10);
        chk32("cont.tlast_positions", lastmask, 32'h0000_0420);
        chk32("cont.bubbles", bubbles, 0);
        chk32("cont.frames", frames, 32'd2);
        chk1("cont.run_after", run, 1'b0);

        // Random backpressure, LEN=3, COUNT=4, GAP=1
        set_cfg(3, 4, 1, 8);
        hs = 0; exp_d = 0; src = 0; bad_data = 0; bad_last = 0; bad_rdy = 0; done = 1'b0;
        s_tdata = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = 8'(src);
            #1;
            if (s_tready && !m_tready) bad_rdy++;
            if (m_tvalid && (s_tready != m_tready)) bad_rdy++;
            if (!m_tvalid && s_tready) bad_rdy++;
            if (m_tvalid && m_tready) begin
                if (m_tdata != 8'(exp_d)) bad_data++;
                exp_d++;
                hs++;
                if (m_tlast != ((hs % 3) == 0)) bad_last++;
            end
            if (s_tvalid && s_tready) src++;
            if (hs > 0 && !busy) done = 1'b1;
            else @(negedge clk);
        end
        m_tready = 1'b1;
        chk1("bp.finished", busy, 1'b0);
        chk32("bp.handshakes", hs, 12);
        chk32("bp.data_errors", bad_data, 0);
        chk32("bp.tlast_errors", bad_last, 0);
        chk32("bp.tready_errors", bad_rdy, 0);
        chk32("bp.frames", frames, 32'd4);

        // Start while busy is ignored; stop during GAP=100 goes idle next cycle
        set_cfg(2, 0, 100, 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        frame_len = 7;
        gap_cycles = 0;
        #1;
        chk1("gap.beat0_tlast", m_tlast, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk1("gap.beat1_tlast_len_kept", m_tlast, 1'b1);
        chk1("gap.error_kept", err, 1'b0);
        @(negedge clk);
        #1;
        chk1("gap.in_gap_busy", busy, 1'b1);
        chk1("gap.in_gap_tvalid", m_tvalid, 1'b0);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        #1;
        chk1("gap.stop_cycle_busy", busy, 1'b1);
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk1("gap.idle_busy", busy, 1'b0);
        chk1("gap.idle_run", run, 1'b0);
        chk32("gap.frames", frames, 32'd1);

        // Reset on beat 2 of LEN=6, then a clean restart
        set_cfg(6, 1, 0, 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk1("rst.run", run, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.error", err, 1'b0);
        chk32("rst.frames", frames, 32'd0);
        chk1("rst.m_tvalid", m_tvalid, 1'b0);
        chk1("rst.m_tlast", m_tlast, 1'b0);
        chk1("rst.s_tready", s_tready, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; lastmask = '0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (m_tvalid && m_tready) begin
                hs++;
                if (m_tlast && hs < 32) lastmask[hs] = 1'b1;
            end
            @(negedge clk);
        end
        chk32("rst.restart_beats", hs, 6);
        chk32("rst.restart_tlast", lastmask, 32'h0000_0040);
        chk32("rst.restart_frames", frames, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_inject_sched.md
Name: sensor_inject_sched

Overview:
- Frame scheduler in front of sensor_inject_ctl.
- Starts the FIFO by driving its run input and passes the recirculating vector stream downstream, framed with TLAST.
- Inserts a programmable idle gap between frames and stops after N frames, or on request at a frame boundary.
- Config comes from the AXI register file.

Parameters:
DW, 8, stream data width
LEN_W, 32, width of frame-length and frame-count fields
GAP_W, 16, width of inter-frame gap field

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
i_START_wstrobe  in  1  start request (pulse)
i_STOP_wstrobe  in  1  graceful stop request (pulse)
i_FRAME_LEN  in  LEN_W  beats per frame
i_FRAME_COUNT  in  LEN_W  frames to send; 0 = continuous
i_GAP_CYCLES  in  GAP_W  idle cycles between frames
i_FIFO_COUNT  in  32  entries in ctl FIFO
o_RUN  out  1  run enable to sensor_inject_ctl
o_BUSY  out  1  1 while not IDLE
o_ERROR  out  1  sticky: start rejected
o_FRAMES_SENT  out  32  completed frames since last accepted start
s_axis_tdata/tvalid/tready  in/in/out  DW/1/1  stream from ctl
m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DW/1/1/1  framed output

Behaviour:
- Reset values: o_RUN=0, o_BUSY=0, o_ERROR=0, o_FRAMES_SENT=0, state IDLE, m_axis_tvalid=0, m_axis_tlast=0.
- States:
  - IDLE: o_RUN=0.
  - STREAM: o_RUN=1.
  - GAP: o_RUN=1.
- Start handling, in IDLE:
  - i_START_wstrobe with i_FRAME_LEN==0 or i_FIFO_COUNT==0: set o_ERROR, stay IDLE.
  - Otherwise: latch LEN, COUNT and GAP; clear o_ERROR, o_FRAMES_SENT, beat_cnt and stop_pend; go to STREAM next cycle.
  - Start outside IDLE is ignored.
- Datapath in STREAM, zero latency, combinational:
  - m_tdata = s_tdata.
  - m_tvalid = s_tvalid.
  - s_tready = m_tready.
  - Outside STREAM: m_tvalid=0 and s_tready=0, so the FIFO is held while o_RUN=1.
- Beat counting in STREAM:
  - Each handshake (m_tvalid & m_tready) increments beat_cnt.
  - m_tlast = (beat_cnt == LEN-1) while in STREAM.
  - The handshake on the TLAST beat ends the frame: o_FRAMES_SENT+1, beat_cnt<=0.
  - Next state after a frame:
    - IDLE if stop_pend, or COUNT!=0 and frames_sent+1==COUNT.
    - Else GAP if GAP!=0.
    - Else STREAM, back-to-back with no bubble.
- GAP: gap_cnt loads GAP-1 on entry and decrements each cycle; at 0 go to STREAM. Exactly GAP idle cycles.
- Stop:
  - i_STOP_wstrobe in STREAM or GAP sets stop_pend.
  - STREAM: stop takes effect at the end of the current frame.
  - GAP: go to IDLE immediately.
  - Stop in IDLE: no effect.
  - Stop and the TLAST handshake in the same cycle: go to IDLE after that frame.
- FIFO position: ctl FIFO rotation position is not restored on stop. A restart continues from wherever the rotation stopped; software clears/reloads if alignment matters.
- Counter widths: o_FRAMES_SENT wraps modulo 2^32 in continuous mode. beat_cnt is LEN_W wide; LEN=1 gives TLAST on every beat.
- Timing of o_RUN: registered; rises the cycle STREAM is entered and falls the cycle IDLE is entered. o_BUSY = (state!=IDLE).
- Config changes while busy have no effect until the next start.
- resetn mid-frame: immediate IDLE, outputs to reset values; the partial frame is not terminated with TLAST.

Optional Feature:
- Macro: SENSOR_INJECT_SCHED_FRAME_TAG_EN.
- Defined:
  - Adds output m_axis_tuser[15:0], carrying the low 16 bits of the current frame index (o_FRAMES_SENT value at frame start) on every beat; 0 when m_tvalid=0.
  - Adds output m_axis_tuser_sof, asserted on the first beat of each frame.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package sensor_inject_pkg:
  - state enum (IDLE, STREAM, GAP);
  - field-width constants LEN_W, GAP_W;
  - constant CONTINUOUS = 0.
- One natural sub-module, sensor_inject_gap_timer: loadable down-counter with done flag, used for GAP.
- Beat and frame counters stay inline.

Test Plan:
- FIFO_COUNT=8, LEN=4, COUNT=3, GAP=2, m_tready=1 -> 12 beats in 3 frames; TLAST on beats 4/8/12; exactly 2 idle cycles between frames; o_FRAMES_SENT=3; o_RUN falls after beat 12.
- LEN=0 or FIFO_COUNT=0 at start -> o_ERROR=1, o_RUN stays 0; a following valid start clears o_ERROR.
- COUNT=0, LEN=5, GAP=0; stop pulsed on beat 7 -> continues to beat 10 with TLAST; o_FRAMES_SENT=2; back-to-back frames have no bubble.
- Random m_tready backpressure, LEN=3, COUNT=4 -> no beat lost or duplicated; s_tready mirrors m_tready only in STREAM; 12 handshakes total.
- Stop during GAP=100 -> IDLE next cycle; a start while busy is ignored (latched config unchanged).
- resetn asserted on beat 2 of LEN=6 -> next cycle all outputs at reset values; a subsequent start streams from beat 0.
